// File: rtl/uart_fir_core.sv
// 8N1 UART transmitter/receiver with a 4-tap moving-average filter on received bytes.
// Define UART_LOOPBACK_EN to feed the receiver from o_Tx_Serial instead of i_Rx_Serial.
module uart_fir_core #(
    parameter int CLKS_PER_BIT = 2,
    parameter int FIR_SHIFT    = 2
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Filt_DV,
    output logic [7:0] o_Filt_Data
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } uart_state_t;

    function automatic logic [7:0] fir_scale(input logic [9:0] sum);
        logic [9:0] shifted;
        shifted = sum >> FIR_SHIFT;
        if (shifted > 10'd255) begin
            return 8'hFF;
        end
        return shifted[7:0];
    endfunction

    uart_state_t      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_serial_q, tx_serial_d;
    logic             tx_active_q, tx_active_d;
    logic             tx_done_q, tx_done_d;

    uart_state_t      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_dv_q, rx_dv_d;
    logic             rx_meta_q, rx_sync_q;
    logic             rx_in;

    logic [7:0]       x1_q, x2_q, x3_q;
    logic [7:0]       filt_q;
    logic             filt_dv_q;
    logic [9:0]       fir_sum;

`ifdef UART_LOOPBACK_EN
    logic unused_rx_serial;
    assign unused_rx_serial = i_Rx_Serial;
    assign rx_in = tx_serial_q;
`else
    assign rx_in = i_Rx_Serial;
`endif

    // Transmitter: serial_d is the bit of the state being entered, so the pin is registered.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_data_d   = tx_data_q;
        tx_serial_d = tx_serial_q;
        tx_active_d = tx_active_q;
        tx_done_d   = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_serial_d = 1'b1;
                tx_cnt_d    = '0;
                tx_idx_d    = '0;
                if (i_Tx_DV) begin
                    tx_data_d   = i_Tx_Byte;
                    tx_active_d = 1'b1;
                    tx_serial_d = 1'b0;
                    tx_state_d  = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_serial_d = tx_data_q[0];
                    tx_state_d  = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_idx_d    = '0;
                        tx_serial_d = 1'b1;
                        tx_state_d  = S_STOP;
                    end else begin
                        tx_idx_d    = tx_idx_q + 3'd1;
                        tx_serial_d = tx_data_q[tx_idx_q + 3'd1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_done_d   = 1'b1;
                    tx_active_d = 1'b0;
                    tx_state_d  = S_CLEANUP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_serial_d = 1'b1;
                tx_state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        tx_data_q <= tx_data_d;
        rx_data_q <= rx_data_d;
    end

    // Receiver: sample point is CNT_MID clocks into START, then every CLKS_PER_BIT clocks.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_data_d  = rx_data_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == CNT_MID) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d            = '0;
                    rx_data_d[rx_idx_q] = rx_sync_q;
                    if (rx_idx_q == 3'd7) begin
                        rx_idx_d   = '0;
                        rx_state_d = S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_CLEANUP;
                    if (rx_sync_q) begin
                        rx_byte_d = rx_data_q;
                        rx_dv_d   = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                rx_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_byte_q  <= '0;
            rx_dv_q    <= 1'b0;
        end else begin
            rx_meta_q  <= rx_in;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    // FIR: o_Rx_Byte serves as tap x0, so the window is complete while o_Rx_DV is high.
    assign fir_sum = 10'(rx_byte_q) + 10'(x1_q) + 10'(x2_q) + 10'(x3_q);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            x1_q      <= '0;
            x2_q      <= '0;
            x3_q      <= '0;
            filt_q    <= '0;
            filt_dv_q <= 1'b0;
        end else begin
            filt_dv_q <= rx_dv_q;
            if (rx_dv_d) begin
                x1_q <= rx_byte_q;
                x2_q <= x1_q;
                x3_q <= x2_q;
            end
            if (rx_dv_q) begin
                filt_q <= fir_scale(fir_sum);
            end
        end
    end

    assign o_Tx_Active = tx_active_q;
    assign o_Tx_Serial = tx_serial_q;
    assign o_Tx_Done   = tx_done_q;
    assign o_Rx_DV     = rx_dv_q;
    assign o_Rx_Byte   = rx_byte_q;
    assign o_Filt_DV   = filt_dv_q;
    assign o_Filt_Data = filt_q;

endmodule

// File: tb/tb_uart_fir_core.sv
// Scoreboard bench for uart_fir_core: TX frames checked bit by bit, RX bytes and filter
// outputs checked against a queue filled by a reference moving-average model.
module tb_uart_fir_core;
    localparam int CPB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       rx_serial;
    logic       tx_active, tx_serial, tx_done;
    logic       rx_dv, filt_dv;
    logic [7:0] rx_byte, filt_data;

    int checks = 0;
    int errors = 0;
    int rx_dv_cnt = 0;
    int tx_done_cnt = 0;
    logic prev_rx_dv = 1'b0;
    int exp_rx_q[$];
    int exp_filt_q[$];
    int h0 = 0, h1 = 0, h2 = 0;

    always #5 clk = ~clk;

    uart_fir_core #(.CLKS_PER_BIT(CPB), .FIR_SHIFT(2)) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Tx_DV    (tx_dv),
        .i_Tx_Byte  (tx_byte),
        .o_Tx_Active(tx_active),
        .o_Tx_Serial(tx_serial),
        .o_Tx_Done  (tx_done),
        .i_Rx_Serial(rx_serial),
        .o_Rx_DV    (rx_dv),
        .o_Rx_Byte  (rx_byte),
        .o_Filt_DV  (filt_dv),
        .o_Filt_Data(filt_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_rx(input int b);
        exp_rx_q.push_back(b);
        exp_filt_q.push_back((b + h0 + h1 + h2) >> 2);
        h2 = h1;
        h1 = h0;
        h0 = b;
    endtask

    task automatic model_reset();
        exp_rx_q.delete();
        exp_filt_q.delete();
        h0 = 0;
        h1 = 0;
        h2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (filt_dv === 1'b1) begin
            check("filt_latency", prev_rx_dv, 1);
            if (exp_filt_q.size() == 0) check("filt_unexpected", 1, 0);
            else check("filt_data", filt_data, exp_filt_q.pop_front());
        end
        if (rx_dv === 1'b1) begin
            rx_dv_cnt++;
            if (exp_rx_q.size() == 0) check("rx_unexpected", 1, 0);
            else check("rx_byte", rx_byte, exp_rx_q.pop_front());
        end
        if (tx_done === 1'b1) tx_done_cnt++;
        prev_rx_dv = rx_dv;
    end

    task automatic check_drained(input string tag);
        check({tag, "_rx_pending"}, exp_rx_q.size(), 0);
        check({tag, "_filt_pending"}, exp_filt_q.size(), 0);
    endtask

    task automatic rx_bit(input logic v);
        rx_serial = v;
        repeat (CPB) tick();
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        if (stop) expect_rx(b);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
        rx_serial = 1'b1;
        repeat (10) tick();
    endtask

    task automatic tx_start(input logic [7:0] b);
        tx_byte = b;
        tx_dv   = 1'b1;
        tick();
        tx_dv   = 1'b0;
    endtask

    task automatic tx_send_check(input logic [7:0] b, input bit inject);
        logic [9:0] frame;
        int done0;
        frame = {1'b1, b, 1'b0};
        done0 = tx_done_cnt;
`ifdef UART_LOOPBACK_EN
        expect_rx(b);
`endif
        tx_start(b);
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            check("tx_serial", tx_serial, frame[c / CPB]);
            check("tx_active", tx_active, 1);
            if (inject && c == 6) begin
                tx_byte = 8'hFF;
                tx_dv   = 1'b1;
            end
            if (inject && c == 7) tx_dv = 1'b0;
        end
        @(negedge clk);
        check("tx_done_pulse", tx_done, 1);
        check("tx_active_drop", tx_active, 0);
        check("tx_idle_line", tx_serial, 1);
        @(negedge clk);
        check("tx_done_single", tx_done, 0);
        repeat (8) @(negedge clk);
        check("tx_no_requeue", tx_active, 0);
        check("tx_done_count", tx_done_cnt - done0, 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int dv0;
        int done0;
        rst       = 1'b1;
        tx_dv     = 1'b0;
        tx_byte   = 8'h00;
`ifdef UART_LOOPBACK_EN
        rx_serial = 1'b0;
`else
        rx_serial = 1'b1;
`endif
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx_serial", tx_serial, 1);
        check("rst_tx_active", tx_active, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_dv", rx_dv, 0);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_filt_dv", filt_dv, 0);
        check("rst_filt_data", filt_data, 0);
        rst = 1'b0;
        tick();

        tx_send_check(8'h55, 1'b0);

`ifndef UART_LOOPBACK_EN
        rx_send(8'hAA, 1'b1);
        check_drained("aa");
        check("filt_42", filt_data, 42);
        rx_send(8'd100, 1'b1);
        check_drained("r100");
        rx_send(8'd50, 1'b1);
        check_drained("r50");
        check("filt_80", filt_data, 80);

        dv0 = rx_dv_cnt;
        rx_serial = 1'b0;
        tick();
        rx_serial = 1'b1;
        repeat (12) tick();
        check("glitch_no_dv", rx_dv_cnt - dv0, 0);

        rx_send(8'h3C, 1'b0);
        check("frame_err_no_dv", rx_dv_cnt - dv0, 0);
        check("frame_err_hold", rx_byte, 50);
`endif

        tx_start(8'hF0);
        repeat (5 * CPB) tick();
        check("abort_mid_active", tx_active, 1);
        done0 = tx_done_cnt;
        rst = 1'b1;
        tick();
        model_reset();
        @(negedge clk);
        check("abort_tx_serial", tx_serial, 1);
        check("abort_tx_active", tx_active, 0);
        check("abort_tx_done", tx_done, 0);
        check("abort_filt_data", filt_data, 0);
        check("abort_rx_byte", rx_byte, 0);
        rst = 1'b0;
        repeat (30) tick();
        check("abort_no_done", tx_done_cnt - done0, 0);
        check("abort_line_idle", tx_serial, 1);

        tx_send_check(8'h81, 1'b1);

`ifdef UART_LOOPBACK_EN
        repeat (4) tick();
        tx_send_check(8'h32, 1'b0);
        repeat (4) tick();
        check_drained("loop32");
        check("loop_rx_byte", rx_byte, 8'h32);
`else
        rx_send(8'h04, 1'b1);
        check_drained("r04");
        check("filt_after_reset", filt_data, 1);
        for (int i = 0; i < 4; i++) rx_send(8'hFF, 1'b1);
        check_drained("rff");
        check("filt_max", filt_data, 255);
`endif

        repeat (4) tick();
        check_drained("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_fir_core.md
Name: uart_fir_core

Overview:
- UART serial front end (8N1 transmitter and receiver) with a 4-tap moving-average FIR filter on the received byte stream.
- Each byte accepted by the receiver is one filter sample; the filtered result is presented on a parallel output.
- The transmitter is independent and is driven by a parallel byte/strobe interface.
- Sits between the board serial pins and downstream processing logic.

Parameters:
- CLKS_PER_BIT, 2, clock cycles per UART bit; legal range ≥2.
- FIR_SHIFT, 2, right shift applied to the 4-sample sum. Fixed 2 gives a divide-by-4 average.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge
- i_Reset  input  1  synchronous, active-high reset
- i_Tx_DV  input  1  one-cycle strobe: transmit i_Tx_Byte
- i_Tx_Byte  input  8  byte to transmit
- o_Tx_Active  output  1  high while a frame is being sent
- o_Tx_Serial  output  1  serial line out, idle high
- o_Tx_Done  output  1  one-cycle pulse at end of stop bit
- i_Rx_Serial  input  1  serial line in, idle high
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte valid
- o_Rx_Byte  output  8  last received byte, held
- o_Filt_DV  output  1  one-cycle pulse: o_Filt_Data updated
- o_Filt_Data  output  8  filter output, held

Behaviour:
- Reset (sync, high):
  - o_Tx_Serial=1; all other outputs 0.
  - Both FSMs go to IDLE; FIR delay line cleared to 0.
  - Reset asserted mid-frame aborts the frame immediately; no partial DV or Done is issued.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT clocks.
- TX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: line high. If i_Tx_DV=1, latch i_Tx_Byte, set o_Tx_Active, go to START.
  - START/DATA/STOP: each drives its bit for CLKS_PER_BIT clocks.
  - At the end of STOP: o_Tx_Done pulses for 1 cycle, o_Tx_Active drops, go to CLEANUP. CLEANUP lasts 1 cycle, then IDLE.
  - i_Tx_DV outside IDLE is ignored; no queuing.
  - Total frame is 10*CLKS_PER_BIT clocks, measured from the first START cycle.
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - Input passes through a 2-flop synchronizer, which adds 2 cycles of latency.
  - IDLE: a low sample enters START.
  - START: sample at (CLKS_PER_BIT-1)/2 clocks. If still low, continue. If high, treat as a glitch and return to IDLE.
  - DATA: sample each bit at mid-bit, every CLKS_PER_BIT clocks, LSB first.
  - STOP: sample at mid-bit.
    - If 1: update o_Rx_Byte and pulse o_Rx_DV for 1 cycle.
    - If 0 (framing error): discard the byte, no DV, o_Rx_Byte unchanged.
  - CLEANUP: 1 cycle, then IDLE. A new start bit is accepted immediately afterwards.
- FIR:
  - On each o_Rx_DV: shift o_Rx_Byte into the 4-deep delay line x0..x3.
  - Next cycle: o_Filt_Data = (x0+x1+x2+x3) >> FIR_SHIFT, with a 10-bit unsigned sum, truncated toward zero. o_Filt_DV pulses the same cycle.
  - Latency: o_Filt_Data is valid exactly 1 clock after o_Rx_DV.
  - Output never overflows: max (4*255)>>2 = 255.
  - Filter is idle between samples and does not advance on plain clocks.

Optional Feature:
- Macro UART_LOOPBACK_EN.
  - Defined: the receiver input is internally tied to o_Tx_Serial and i_Rx_Serial is ignored. o_Tx_Serial is still driven to the port.
  - Undefined: the receiver uses i_Rx_Serial.

Test Plan:
- TX 0x55: reset, pulse i_Tx_DV with 0x55 → o_Tx_Serial = 0,1,0,1,0,1,0,1,0,1, each bit 2 clocks. o_Tx_Active high for 20 clocks. One o_Tx_Done pulse.
- RX 0xAA: drive 0xAA frame, 2 clocks/bit → one o_Rx_DV, o_Rx_Byte=0xAA. Then o_Filt_Data = 170>>2 = 42 one clock later.
- FIR sequence, continuing from the 0xAA test:
  - RX 100 → o_Filt_Data = (170+100)>>2 = 67.
  - Then RX 50 → (170+100+50)>>2 = 80.
- Errors:
  - Start glitch: low for 1 clock → no o_Rx_DV.
  - Stop bit 0 with data 0x3C → no o_Rx_DV, o_Rx_Byte unchanged.
- Reset mid-frame: assert i_Reset during TX bit 4 → o_Tx_Serial=1, o_Tx_Active=0, no o_Tx_Done, o_Filt_Data=0. Next TX of 0x81 completes correctly.
- Loopback, with UART_LOOPBACK_EN defined: send 0x32 via TX → o_Rx_Byte=0x32, o_Rx_DV pulses.
